// File: rtl/counter_interval_arbiter_pkg.sv
// counter_interval_arbiter_pkg: shared states, default sizes and round-robin pick
package counter_interval_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NUM_REQ_D = 4;
  localparam int CNT_W_D = 4;
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
    logic [2:0] pick;
    logic found;
    pick = ptr;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      int idx;
      idx = (int'(ptr) + k) % n;
      if (k <= n && !found && req[3'(idx)]) begin
        pick = 3'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction
endpackage

// File: rtl/counter_interval_arbiter_if.sv
// counter_interval_arbiter_if: requester-side bundle of the shared interval counter
interface counter_interval_arbiter_if
  import counter_interval_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_D,
  parameter int CNT_W = CNT_W_D
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*CNT_W-1:0] len;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] done;
  logic busy;
  logic [CNT_W-1:0] count_out;
  modport master(output req, len, input grant, done, busy, count_out);
  modport slave(input req, len, output grant, done, busy, count_out);
endinterface

// File: rtl/counter_interval_arbiter_interval_counter.sv
// interval_counter: up-counter with synchronous clear taking priority over enable
module interval_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);
  always_ff @(posedge clock)
    if (reset || clear) count <= '0;
    else if (enable) count <= count + W'(1);
endmodule

// File: rtl/counter_interval_arbiter.sv
// counter_interval_arbiter: round-robin sharing of one interval counter among requesters
module counter_interval_arbiter
  import counter_interval_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_D,
  parameter int CNT_W = CNT_W_D
) (
  input logic clock,
  input logic reset,
  counter_interval_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  state_t state, state_n;
  logic [IW-1:0] owner, ptr, pick;
  logic [CNT_W-1:0] len_q, count;
  logic [NUM_REQ-1:0] owner_oh;
  logic abort, hit, clear, enable;
  assign pick = IW'(rr_pick(8'(bus.req), 3'(ptr), NUM_REQ));
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      ptr <= IW'(NUM_REQ - 1);
      owner <= '0;
      len_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && |bus.req) begin
        owner <= pick;
        ptr <= pick;
        len_q <= bus.len[int'(pick)*CNT_W +: CNT_W];
      end
    end
  // abort outranks reaching the terminal count, so a dropped request never sees done
  always_comb begin
    abort = state == RUN && !bus.req[owner];
    hit = count == len_q;
    state_n = state == IDLE ? (|bus.req ? RUN : IDLE)
            : state == RUN  ? (abort ? IDLE : hit ? DONE : RUN)
            : IDLE;
    clear = state != RUN || abort;
    enable = state == RUN && !hit;
    owner_oh = NUM_REQ'(1) << owner;
    bus.grant = state == IDLE ? '0 : owner_oh;
    bus.done = state == DONE ? owner_oh : '0;
    bus.busy = state != IDLE;
    bus.count_out = count;
  end
  interval_counter #(.W(CNT_W)) u_cnt (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .enable(enable),
    .count(count)
  );
endmodule

// File: tb/tb_counter_interval_arbiter.sv
// tb_counter_interval_arbiter: directed plan plus random traffic against a grant-timeline model
module tb_counter_interval_arbiter;
  localparam int N = 4;
  localparam int W = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int m_own = -1, m_t = 0, m_len = 0, m_ptr = N - 1;
  counter_interval_arbiter_if #(.NUM_REQ(N), .CNT_W(W)) bus ();
  counter_interval_arbiter #(.NUM_REQ(N), .CNT_W(W)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // the model tracks only who owns the counter and how far into its timeline it is
  task automatic model(input logic [N-1:0] r, input logic [N*W-1:0] l, input logic rs);
    if (rs) begin
      m_own = -1;
      m_ptr = N - 1;
    end else if (m_own < 0) begin
      for (int k = 1; k <= N; k++) begin
        int idx = (m_ptr + k) % N;
        if (m_own < 0 && r[idx]) begin
          m_own = idx;
          m_ptr = idx;
          m_len = int'(l[idx*W +: W]);
          m_t = 0;
        end
      end
    end else if (m_t <= m_len) begin
      if (!r[m_own]) m_own = -1;
      else m_t++;
    end else m_own = -1;
  endtask
  task automatic check_all();
    logic [N-1:0] eg;
    eg = m_own < 0 ? '0 : N'(1 << m_own);
    chk("grant", 32'(bus.grant), 32'(eg));
    chk("done", 32'(bus.done), m_own >= 0 && m_t == m_len + 1 ? 32'(eg) : 32'd0);
    chk("busy", 32'(bus.busy), 32'(m_own >= 0));
    chk("count_out", 32'(bus.count_out), m_own < 0 ? 32'd0 : 32'(m_t > m_len ? m_len : m_t));
    chk("invariant", 32'($onehot0(bus.grant) && (bus.done & ~bus.grant) == '0), 32'd1);
  endtask
  task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] l, input logic rs);
    bus.req = r;
    bus.len = l;
    reset = rs;
    @(posedge clock);
    model(r, l, rs);
    @(negedge clock);
    check_all();
  endtask
  initial begin
    int mx, nd;
    bus.req = '0;
    bus.len = '0;
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);
    chk("reset_grant", 32'(bus.grant), 32'd0);
    // plan 1: single requester, len 3
    step(4'b0001, 16'h0003, 1'b0);
    chk("t1_grant", 32'(bus.grant), 32'd1);
    repeat (6) step(4'b0001, 16'h0003, 1'b0);
    // plan 2: all requesting with zero lengths rotates fairly
    step('0, '0, 1'b1);
    repeat (16) step(4'b1111, 16'h0000, 1'b0);
    // plan 3: maximum length must not wrap
    step('0, '0, 1'b1);
    step(4'b0001, 16'h000f, 1'b0);
    mx = 0;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      step(4'b0001, 16'h000f, 1'b0);
      if (int'(bus.count_out) > mx) mx = int'(bus.count_out);
      if (bus.done != '0) nd++;
    end
    chk("t3_max", 32'(mx), 32'd15);
    chk("t3_done_cnt", 32'(nd), 32'd1);
    // plan 4: abort of requester 2 at count 4, requester 3 waiting
    step('0, '0, 1'b1);
    step(4'b0100, 16'h0a00, 1'b0);
    for (int i = 0; i < 30 && bus.count_out !== 4'd4; i++) step(4'b1100, 16'h5a00, 1'b0);
    chk("t4_reach", 32'(bus.count_out), 32'd4);
    step(4'b1000, 16'h5a00, 1'b0);
    chk("t4_abort_count", 32'(bus.count_out), 32'd0);
    chk("t4_abort_done", 32'(bus.done), 32'd0);
    step(4'b1000, 16'h5a00, 1'b0);
    chk("t4_next_grant", 32'(bus.grant), 32'd8);
    repeat (8) step(4'b1000, 16'h5a00, 1'b0);
    // plan 5: reset mid-run, then index 0 wins first
    step('0, '0, 1'b1);
    step(4'b0001, 16'h0009, 1'b0);
    for (int i = 0; i < 30 && bus.count_out !== 4'd6; i++) step(4'b0001, 16'h0009, 1'b0);
    chk("t5_reach", 32'(bus.count_out), 32'd6);
    step(4'b0001, 16'h0009, 1'b1);
    chk("t5_reset_busy", 32'(bus.busy), 32'd0);
    step(4'b0011, 16'h0011, 1'b0);
    chk("t5_first", 32'(bus.grant), 32'd1);
    repeat (10) step(4'b0011, 16'h0011, 1'b0);
    // plan 6: length change after latch is ignored
    step('0, '0, 1'b1);
    step(4'b0010, 16'h0020, 1'b0);
    repeat (6) step(4'b0010, 16'h0090, 1'b0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r;
      logic [N*W-1:0] l;
      r = N'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      for (int k = 0; k < N; k++) l[k*W +: W] = W'($urandom_range(0, 5));
      step(r, l, $urandom_range(0, 59) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
